// File: rtl/i2c_rx_byte.sv
// I2C byte receiver: tracks SCL from edge pulses, detects START/STOP, shifts in
// 8 bits MSB first and sequences the ACK bit window. All outputs are registered.
module i2c_rx_byte (
    input  logic       clk,
    input  logic       rst,
    input  logic       rising_edge_found,
    input  logic       falling_edge_found,
    input  logic       sda_in,
    output logic [7:0] rx_data,
    output logic       byte_received,
    output logic       ack_prep,
    output logic       ack_done,
    output logic       start_found,
    output logic       stop_found
);

    typedef enum logic [1:0] {StIdle, StRecv, StAckWait, StAck} state_e;

    state_e      state_q, state_d;
    logic        scl_level_q, scl_level_d;
    logic        sda_prev_q;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        byte_q, byte_d;
    logic        ack_prep_q, ack_prep_d;
    logic        ack_done_q, ack_done_d;
    logic        start_q, start_d;
    logic        stop_q, stop_d;

    logic edge_any, rise_v, fall_v, start_det, stop_det;

    // A coincident rise/fall pair is ambiguous and is dropped entirely.
    assign edge_any  = rising_edge_found | falling_edge_found;
    assign rise_v    = rising_edge_found & ~falling_edge_found;
    assign fall_v    = falling_edge_found & ~rising_edge_found;
    assign start_det = scl_level_q & sda_prev_q & ~sda_in & ~edge_any;
    assign stop_det  = scl_level_q & ~sda_prev_q & sda_in & ~edge_any;

    always_comb begin
        scl_level_d = scl_level_q;
        if (rise_v) begin
            scl_level_d = 1'b1;
        end else if (fall_v) begin
            scl_level_d = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        byte_d     = 1'b0;
        ack_prep_d = ack_prep_q;
        ack_done_d = 1'b0;
        start_d    = 1'b0;
        stop_d     = 1'b0;
        if (start_det) begin
            start_d    = 1'b1;
            state_d    = StRecv;
            cnt_d      = 4'd0;
            shift_d    = 8'h00;
            ack_prep_d = 1'b0;
        end else if (stop_det) begin
            stop_d     = 1'b1;
            state_d    = StIdle;
            ack_prep_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: ;
                StRecv: begin
                    if (rise_v) begin
                        shift_d = {shift_q[6:0], sda_in};
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            rx_data_d = {shift_q[6:0], sda_in};
                            byte_d    = 1'b1;
                            state_d   = StAckWait;
                        end
                    end
                end
                StAckWait: begin
                    if (fall_v) begin
                        state_d    = StAck;
                        ack_prep_d = 1'b1;
                    end
                end
                StAck: begin
                    if (fall_v) begin
                        ack_prep_d = 1'b0;
                        ack_done_d = 1'b1;
                        cnt_d      = 4'd0;
                        state_d    = StRecv;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            scl_level_q <= 1'b1;
            sda_prev_q  <= 1'b1;
            cnt_q       <= 4'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            byte_q      <= 1'b0;
            ack_prep_q  <= 1'b0;
            ack_done_q  <= 1'b0;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            scl_level_q <= scl_level_d;
            sda_prev_q  <= sda_in;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            byte_q      <= byte_d;
            ack_prep_q  <= ack_prep_d;
            ack_done_q  <= ack_done_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign byte_received = byte_q;
    assign ack_prep      = ack_prep_q;
    assign ack_done      = ack_done_q;
    assign start_found   = start_q;
    assign stop_found    = stop_q;

endmodule

// File: tb/tb_i2c_rx_byte.sv
// Self-checking bench for i2c_rx_byte: bus-level stimulus with a transaction-level
// reference model of the expected received bytes.
module tb_i2c_rx_byte;

    logic       clk = 1'b0;
    logic       rst;
    logic       rise, fall, sda;
    logic [7:0] rx_data;
    logic       byte_received, ack_prep, ack_done, start_found, stop_found;

    int n_checks = 0;
    int n_fail   = 0;

    // Pulse counters observed from the DUT
    int byte_cnt = 0, start_cnt = 0, stop_cnt = 0, done_cnt = 0;

    // Reference model state
    bit         scl_hi;
    bit         active, ack_pending;
    int         bits_n, acc, exp_byte_cnt;
    logic [7:0] exp_last;

    always #5 clk = ~clk;

    i2c_rx_byte dut (
        .clk               (clk),
        .rst               (rst),
        .rising_edge_found (rise),
        .falling_edge_found(fall),
        .sda_in            (sda),
        .rx_data           (rx_data),
        .byte_received     (byte_received),
        .ack_prep          (ack_prep),
        .ack_done          (ack_done),
        .start_found       (start_found),
        .stop_found        (stop_found)
    );

    // One clock; afterwards the outputs reflect the inputs that were just latched.
    task automatic cycle();
        @(posedge clk);
        #1;
        rise = 1'b0;
        fall = 1'b0;
        if (byte_received === 1'b1) byte_cnt++;
        if (start_found === 1'b1) start_cnt++;
        if (stop_found === 1'b1) stop_cnt++;
        if (ack_done === 1'b1) done_cnt++;
    endtask

    task automatic scl_rise();
        rise = 1'b1;
        cycle();
        scl_hi = 1'b1;
    endtask

    task automatic scl_fall();
        fall = 1'b1;
        cycle();
        scl_hi = 1'b0;
    endtask

    task automatic set_sda(input logic b);
        sda = b;
        cycle();
    endtask

    task automatic model_clear();
        ack_pending = 1'b0;
        bits_n      = 0;
        acc         = 0;
    endtask

    // START (or repeated START), leaving SCL low afterwards.
    task automatic bus_start();
        if (!scl_hi) begin
            set_sda(1'b1);
            scl_rise();
        end else if (sda !== 1'b1) begin
            set_sda(1'b1);
        end
        set_sda(1'b0);
        active = 1'b1;
        model_clear();
        scl_fall();
    endtask

    // STOP, leaving SCL high and SDA high.
    task automatic bus_stop();
        if (scl_hi) scl_fall();
        set_sda(1'b0);
        scl_rise();
        set_sda(1'b1);
        active = 1'b0;
        model_clear();
    endtask

    task automatic send_bit(input logic b);
        set_sda(b);
        scl_rise();
        cycle();
        scl_fall();
        if (active && !ack_pending) begin
            acc = acc * 2 + int'(b);
            bits_n++;
            if (bits_n == 8) begin
                exp_last = acc[7:0];
                exp_byte_cnt++;
                ack_pending = 1'b1;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_ack();
        set_sda(1'b0);
        scl_rise();
        cycle();
        scl_fall();
        if (ack_pending) model_clear();
    endtask

    task automatic test_reset();
        rst = 1'b1; rise = 1'b0; fall = 1'b0; sda = 1'b1; scl_hi = 1'b1;
        active = 1'b0; exp_byte_cnt = 0; exp_last = 8'h00;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (rx_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_rx_data: got %h want 00", rx_data);
        end
        n_checks++;
        if ({byte_received, ack_prep, ack_done, start_found, stop_found} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 00000",
                     {byte_received, ack_prep, ack_done, start_found, stop_found});
        end
        rst = 1'b0;
        cycle();
        cycle();
        n_checks++;
        if (start_cnt + stop_cnt + byte_cnt !== 0) begin
            n_fail++;
            $display("FAIL reset_idle_pulses: got %0d want 0", start_cnt + stop_cnt + byte_cnt);
        end
    endtask

    task automatic test_byte_a5();
        int s0, b0;
        s0 = start_cnt;
        bus_start();
        n_checks++;
        if (start_cnt !== s0 + 1) begin
            n_fail++; $display("FAIL a5_start: got %0d want %0d", start_cnt, s0 + 1);
        end
        b0 = byte_cnt;
        send_byte(8'hA5);
        n_checks++;
        if (byte_cnt !== b0 + 1 || byte_cnt !== exp_byte_cnt) begin
            n_fail++; $display("FAIL a5_count: got %0d want %0d", byte_cnt, exp_byte_cnt);
        end
        n_checks++;
        if (rx_data !== 8'hA5 || rx_data !== exp_last) begin
            n_fail++; $display("FAIL a5_data: got %h want a5", rx_data);
        end
    endtask

    // Continues directly from test_byte_a5: the last bit's SCL fall has just been latched.
    task automatic test_ack_and_second();
        n_checks++;
        if (ack_prep !== 1'b1) begin
            n_fail++; $display("FAIL ack_rise: got %b want 1", ack_prep);
        end
        set_sda(1'b0);
        scl_rise();
        cycle();
        n_checks++;
        if (ack_prep !== 1'b1 || ack_done !== 1'b0) begin
            n_fail++; $display("FAIL ack_hold: got prep=%b done=%b want 1/0", ack_prep, ack_done);
        end
        scl_fall();
        model_clear();
        n_checks++;
        if (ack_done !== 1'b1 || ack_prep !== 1'b0) begin
            n_fail++; $display("FAIL ack_end: got done=%b prep=%b want 1/0", ack_done, ack_prep);
        end
        cycle();
        n_checks++;
        if (ack_done !== 1'b0) begin
            n_fail++; $display("FAIL ack_done_pulse: got %b want 0", ack_done);
        end
        send_byte(8'h3C);
        n_checks++;
        if (rx_data !== 8'h3C || byte_cnt !== exp_byte_cnt) begin
            n_fail++;
            $display("FAIL second_byte: got %h/%0d want 3c/%0d", rx_data, byte_cnt, exp_byte_cnt);
        end
        send_ack();
    endtask

    task automatic test_repeated_start();
        int s0;
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        s0 = start_cnt;
        bus_start();
        n_checks++;
        if (start_cnt !== s0 + 1) begin
            n_fail++; $display("FAIL rs_start: got %0d want %0d", start_cnt, s0 + 1);
        end
        send_byte(8'hFF);
        n_checks++;
        if (rx_data !== 8'hFF || byte_cnt !== exp_byte_cnt) begin
            n_fail++;
            $display("FAIL rs_data: got %h/%0d want ff/%0d", rx_data, byte_cnt, exp_byte_cnt);
        end
    endtask

    // Continues in the ACK window of the 0xFF byte.
    task automatic test_stop_in_ack();
        int p0;
        n_checks++;
        if (ack_prep !== 1'b1) begin
            n_fail++; $display("FAIL stop_pre_ack: got %b want 1", ack_prep);
        end
        p0 = stop_cnt;
        bus_stop();
        n_checks++;
        if (stop_found !== 1'b1 || stop_cnt !== p0 + 1) begin
            n_fail++; $display("FAIL stop_pulse: got %b/%0d want 1/%0d", stop_found, stop_cnt, p0 + 1);
        end
        n_checks++;
        if (ack_prep !== 1'b0) begin
            n_fail++; $display("FAIL stop_ack_prep: got %b want 0", ack_prep);
        end
        scl_fall();
        for (int k = 0; k < 10; k++) send_bit(1'($urandom_range(0, 1)));
        n_checks++;
        if (byte_cnt !== exp_byte_cnt || rx_data !== exp_last) begin
            n_fail++;
            $display("FAIL stop_idle: got %0d/%h want %0d/%h", byte_cnt, rx_data, exp_byte_cnt, exp_last);
        end
    endtask

    task automatic test_reset_midbyte();
        bus_start();
        send_byte(8'h5A);
        send_ack();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (rx_data !== 8'h00 || {byte_received, ack_prep, ack_done, start_found, stop_found} !== 5'b0)
        begin
            n_fail++; $display("FAIL async_reset: got rx=%h want 00 and flags 0", rx_data);
        end
        active = 1'b0; exp_last = 8'h00;
        model_clear();
        sda = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        scl_hi = 1'b1;
        cycle();
        scl_fall();
        for (int i = 0; i < 8; i++) send_bit(1'($urandom_range(0, 1)));
        n_checks++;
        if (byte_cnt !== exp_byte_cnt || rx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_no_start: got %0d/%h want %0d/00", byte_cnt, rx_data, exp_byte_cnt);
        end
    endtask

    task automatic test_simultaneous_edges();
        logic [7:0] v;
        v = 8'($urandom);
        bus_start();
        for (int i = 7; i >= 5; i--) send_bit(v[i]);
        rise = 1'b1;
        fall = 1'b1;
        cycle();
        for (int i = 4; i >= 0; i--) send_bit(v[i]);
        n_checks++;
        if (rx_data !== v || byte_cnt !== exp_byte_cnt) begin
            n_fail++;
            $display("FAIL simul_edges: got %h/%0d want %h/%0d", rx_data, byte_cnt, v, exp_byte_cnt);
        end
        send_ack();
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        bus_start();
        for (int n = 0; n < 8; n++) begin
            v = 8'($urandom);
            if ($urandom_range(0, 3) == 0) bus_start();
            send_byte(v);
            n_checks++;
            if (rx_data !== exp_last || byte_cnt !== exp_byte_cnt) begin
                n_fail++;
                $display("FAIL b2b_byte%0d: got %h/%0d want %h/%0d",
                         n, rx_data, byte_cnt, exp_last, exp_byte_cnt);
            end
            send_ack();
        end
        n_checks++;
        if (done_cnt < 8) begin
            n_fail++; $display("FAIL b2b_ack_done: got %0d want >=8", done_cnt);
        end
        bus_stop();
    endtask

    initial begin
        test_reset();
        test_byte_a5();
        test_ack_and_second();
        test_repeated_start();
        test_stop_in_ack();
        test_reset_midbyte();
        test_simultaneous_edges();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_rx_byte.md
I2C_RX_BYTE -- requirements
Module: i2c_rx_byte

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port rising_edge_found, input, 1 bit: one-cycle pulse from the SCL edge detector for an SCL rise.
REQ-004 SHALL have port falling_edge_found, input, 1 bit: one-cycle pulse from the SCL edge detector for an SCL fall.
REQ-005 SHALL have port sda_in, input, 1 bit: SDA, synchronized and delayed to the same pipeline depth as the edge pulses (upstream responsibility).
REQ-006 SHALL have port rx_data, output, 8 bits: last complete received byte, MSB first.
REQ-007 SHALL have port byte_received, output, 1 bit: one-cycle pulse when rx_data updates.
REQ-008 SHALL have port ack_prep, output, 1 bit: level, high for the full ACK bit period (SCL low-high-low).
REQ-009 SHALL have port ack_done, output, 1 bit: one-cycle pulse at the SCL fall ending the ACK bit.
REQ-010 SHALL have port start_found, output, 1 bit: one-cycle pulse on START or repeated START.
REQ-011 SHALL have port stop_found, output, 1 bit: one-cycle pulse on STOP.

Function
REQ-012 SHALL track scl_level internally: set on rising_edge_found, cleared on falling_edge_found.
REQ-013 SHALL register sda_prev = sda_in every cycle.
REQ-014 SHALL detect START when scl_level=1, sda_prev=1, sda_in=0 and no edge pulse is present that cycle.
REQ-015 SHALL detect STOP when scl_level=1, sda_prev=0, sda_in=1 and no edge pulse is present that cycle.
REQ-016 SHALL implement FSM states IDLE, RECV, ACK_WAIT, ACK.
REQ-017 SHALL, in any state, on START: pulse start_found next cycle, enter RECV, clear the bit counter and the shift register.
REQ-018 SHALL, in any state, on STOP: pulse stop_found next cycle, enter IDLE, deassert ack_prep; START/STOP take priority over all other transitions.
REQ-019 SHALL, in IDLE, ignore all edge pulses.
REQ-020 SHALL, in RECV on rising_edge_found, shift sda_in into the LSB of the 8-bit shift register and increment a 4-bit bit counter.
REQ-021 SHALL, on the 8th rising edge in RECV, load rx_data with {shift[6:0], sda_in}, pulse byte_received next cycle and enter ACK_WAIT.
REQ-022 SHALL, in ACK_WAIT on falling_edge_found, enter ACK and assert ack_prep from the next cycle.
REQ-023 SHALL, in ACK, ignore rising_edge_found and, on falling_edge_found, deassert ack_prep, pulse ack_done, clear the counter and re-enter RECV.
REQ-024 SHALL ignore both pulses if rising_edge_found and falling_edge_found are asserted in the same cycle (neither scl_level nor FSM change).
REQ-025 SHALL hold rx_data stable except on the byte_received update.
REQ-026 SHALL have all outputs registered, with one-cycle latency from the triggering input cycle.

Reset
REQ-027 SHALL, while rst=1, force: FSM=IDLE, scl_level=1, sda_prev=1, counter=0, shift register=0x00, rx_data=0x00, byte_received=0, ack_prep=0, ack_done=0, start_found=0, stop_found=0.
REQ-028 SHALL, when rst asserts mid-byte, discard the partial byte and require a fresh START after release.

Verification
REQ-029 Reset, then START, then bits 1,0,1,0,0,1,0,1 on 8 SCL pulses -> byte_received pulses exactly once, rx_data=0xA5.
REQ-030 After 0xA5 -> ack_prep rises the cycle after the next SCL fall; it stays high through SCL high; at the following fall ack_done pulses and ack_prep=0; a second byte 0x3C then yields rx_data=0x3C.
REQ-031 Repeated START after 4 bits -> start_found pulses, the counter restarts, and the next 8 bits 0xFF give rx_data=0xFF (not a mix).
REQ-032 STOP during ACK -> stop_found pulses, ack_prep drops next cycle, FSM=IDLE, and later SCL pulses without START produce no byte_received.
REQ-033 rst asserted after 5 bits -> all outputs 0 immediately (asynchronously); after release, 8 SCL pulses without START produce no byte_received.
REQ-034 Rising and falling pulses asserted in the same cycle during RECV -> the counter is unchanged and the next valid 8 bits still give the correct byte.
